ram_store_ctrl: RTL and testbench

- Parametrised store-data path and SRAM write sequencer for the MEM stage.
- Selects write data from NUM_SRC sources (default REGA/REGB/RA), captures it with the address, and drives an asynchronous SRAM through a timed write (setup / WE-low / hold) with a valid/ready handshake.
- While a write is in flight, req_ready=0; the pipeline stalls on req_valid & ~req_ready.

---
 rtl/ram_store_ctrl_pkg.sv | 31 +++
 rtl/ram_wr_src_mux.sv | 36 +++
 rtl/ram_store_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ram_store_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_store_ctrl_pkg.sv
// Shared constants for the MEM-stage store path: FSM encodings, source
// indices and default SRAM write timing.
package ram_store_ctrl_pkg;

    // Write sequencer states (2-bit, legacy-compatible encoding)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WE    = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Store-data source indices on the flattened source bus
    localparam int SRC_REGA = 0;
    localparam int SRC_REGB = 1;
    localparam int SRC_RA   = 2;

    // Default SRAM write timing, in clock cycles
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_WE_CYC    = 2;
    localparam int DEF_HOLD_CYC  = 1;

    // Largest of the three phase lengths; sizes the shared down-counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 1) m = 1;
        return m;
    endfunction

endpackage

// File: rtl/ram_wr_src_mux.sv
// NUM_SRC:1 store-data selector. Purely combinational; flags selects that
// point past the last implemented source so the caller can drop the request.
module ram_wr_src_mux
    import ram_store_ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [DATA_W-1:0]         data,
    output logic                      sel_err
);

    // One extra bit so NUM_SRC == 2**SEL_W still compares correctly
    localparam int SELX_W = SEL_W + 1;
    localparam logic [SELX_W-1:0] NUM_SRC_X = SELX_W'(NUM_SRC);

    logic [NUM_SRC-1:0][DATA_W-1:0] src_arr;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_arr[g] = src_data[g*DATA_W +: DATA_W];
    end

    // Pick the addressed source; out-of-range selects yield zero data
    always_comb begin
        data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) data = src_arr[i];
        end
    end

    assign sel_err = ({1'b0, sel} >= NUM_SRC_X);

endmodule

// File: rtl/ram_store_ctrl.sv
// MEM-stage store sequencer: captures address and selected data on accept,
// then walks the asynchronous SRAM through setup / WE-low / hold. All RAM
// strobes come straight from flops decoded off the next state.
module ram_store_ctrl
    import ram_store_ctrl_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int NUM_SRC   = 3,
    parameter int SEL_W     = 2,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WE_CYC    = DEF_WE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SEL_W-1:0]          req_sel,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_data_out,
    output logic                      ram_data_oe,
    output logic                      ram_ce_n,
    output logic                      ram_we_n,
    output logic                      done,
    output logic                      sel_err,
    output logic [DATA_W-1:0]         last_data
);

    localparam int MAX_CYC = max3(SETUP_CYC, WE_CYC, HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] CNT_WE    = CNT_W'(WE_CYC);
    localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(HOLD_CYC);

    logic [1:0]       state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [DATA_W-1:0] mux_data;
    logic             mux_err;
    logic             accept;
    logic             start;
    logic             last_step;
    logic             finish;

    ram_wr_src_mux #(
        .DATA_W  (DATA_W),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .sel      (req_sel),
        .src_data (src_data),
        .data     (mux_data),
        .sel_err  (mux_err)
    );

    // Ready depends on state only, so there is no valid->ready loop
    assign req_ready = (state == ST_IDLE) & ~rst;
    assign accept    = req_valid & req_ready;
    assign start     = accept & ~mux_err;
    assign last_step = (cnt == CNT_ONE);
    assign finish    = (state != ST_IDLE) && (nxt_state == ST_IDLE);

    // Next state and counter: counter is loaded on entry, state advances at 1
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (SETUP_CYC > 0) begin
                        nxt_state = ST_SETUP;
                        nxt_cnt   = CNT_SETUP;
                    end else begin
                        nxt_state = ST_WE;
                        nxt_cnt   = CNT_WE;
                    end
                end
            end
            ST_SETUP: begin
                if (last_step) begin
                    nxt_state = ST_WE;
                    nxt_cnt   = CNT_WE;
                end else begin
                    nxt_cnt = cnt - CNT_ONE;
                end
            end
            ST_WE: begin
                if (last_step) begin
                    if (HOLD_CYC > 0) begin
                        nxt_state = ST_HOLD;
                        nxt_cnt   = CNT_HOLD;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_cnt   = '0;
                    end
                end else begin
                    nxt_cnt = cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (last_step) begin
                    nxt_state = ST_IDLE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = cnt - CNT_ONE;
                end
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // State and phase counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    // SRAM strobes registered from the next state so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_ce_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_data_oe <= 1'b0;
        end else begin
            ram_ce_n    <= (nxt_state == ST_IDLE);
            ram_we_n    <= (nxt_state != ST_WE);
            ram_data_oe <= (nxt_state != ST_IDLE);
        end
    end

    // Address/data captured only on a valid accept, held until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr     <= '0;
            ram_data_out <= '0;
        end else if (start) begin
            ram_addr     <= req_addr;
            ram_data_out <= mux_data;
        end
    end

    // Completion / drop pulses and the record of the last finished write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            sel_err   <= 1'b0;
            last_data <= '0;
        end else begin
            done    <= finish;
            sel_err <= accept & mux_err;
            if (finish) last_data <= ram_data_out;
        end
    end

endmodule

// File: tb/tb_ram_store_ctrl.sv
// Self-checking bench for ram_store_ctrl: phase-based reference model for the
// default-timing instance, vector table, directed sequences, and two extra
// instances for the timing corners.
module tb_ram_store_ctrl;
    import ram_store_ctrl_pkg::*;

    localparam int S  = 1;
    localparam int W  = 2;
    localparam int H  = 1;
    localparam int T  = S + W + H;
    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        v0 = 1'b0;
    logic        v2 = 1'b0;
    logic [1:0]  req_sel = '0;
    logic [15:0] req_addr = '0;
    logic [47:0] src_data = '0;

    logic        req_ready, ram_data_oe, ram_ce_n, ram_we_n, done, sel_err;
    logic [15:0] ram_addr, ram_data_out, last_data;

    logic        c0_ready, c0_oe, c0_ce_n, c0_we_n, c0_done, c0_err;
    logic [15:0] c0_addr, c0_data, c0_last;
    logic        c2_ready, c2_oe, c2_ce_n, c2_we_n, c2_done, c2_err;
    logic [15:0] c2_addr, c2_data, c2_last;

    always #5 clk = ~clk;

    ram_store_ctrl #(.DATA_W(16), .ADDR_W(16), .NUM_SRC(NS), .SEL_W(2),
                     .SETUP_CYC(S), .WE_CYC(W), .HOLD_CYC(H)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_addr(req_addr), .src_data(src_data),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_oe(ram_data_oe),
        .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n), .done(done), .sel_err(sel_err),
        .last_data(last_data));

    ram_store_ctrl #(.DATA_W(16), .ADDR_W(16), .NUM_SRC(NS), .SEL_W(2),
                     .SETUP_CYC(0), .WE_CYC(1), .HOLD_CYC(0)) dut_c0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(c0_ready),
        .req_sel(req_sel), .req_addr(req_addr), .src_data(src_data),
        .ram_addr(c0_addr), .ram_data_out(c0_data), .ram_data_oe(c0_oe),
        .ram_ce_n(c0_ce_n), .ram_we_n(c0_we_n), .done(c0_done), .sel_err(c0_err),
        .last_data(c0_last));

    ram_store_ctrl #(.DATA_W(16), .ADDR_W(16), .NUM_SRC(NS), .SEL_W(2),
                     .SETUP_CYC(2), .WE_CYC(2), .HOLD_CYC(3)) dut_c2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(c2_ready),
        .req_sel(req_sel), .req_addr(req_addr), .src_data(src_data),
        .ram_addr(c2_addr), .ram_data_out(c2_data), .ram_data_oe(c2_oe),
        .ram_ce_n(c2_ce_n), .ram_we_n(c2_we_n), .done(c2_done), .sel_err(c2_err),
        .last_data(c2_last));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase = cycles since accept (0 = idle)
    int          mp = 0;
    logic        m_done = 1'b0, m_err = 1'b0;
    logic [15:0] m_addr = '0, m_data = '0, m_last = '0;

    task automatic model_reset();
        mp = 0; m_done = 1'b0; m_err = 1'b0;
        m_addr = '0; m_data = '0; m_last = '0;
    endtask

    task automatic model_adv(input logic v, input logic [1:0] s,
                             input logic [15:0] a, input logic [47:0] src);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (mp == 0) begin
            if (v) begin
                if (int'(s) < NS) begin
                    m_addr = a;
                    m_data = src[int'(s)*16 +: 16];
                    mp = 1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (mp == T) begin
            mp = 0;
            m_done = 1'b1;
            m_last = m_data;
        end else begin
            mp++;
        end
    endtask

    task automatic check_cycle();
        chk("ready",     req_ready,    mp == 0);
        chk("ce_n",      ram_ce_n,     !(mp >= 1));
        chk("we_n",      ram_we_n,     !(mp >= S + 1 && mp <= S + W));
        chk("oe",        ram_data_oe,  mp >= 1);
        chk("done",      done,         m_done);
        chk("sel_err",   sel_err,      m_err);
        chk("ram_addr",  ram_addr,     m_addr);
        chk("ram_data",  ram_data_out, m_data);
        chk("last_data", last_data,    m_last);
    endtask

    // Called at a negedge: check this cycle, drive inputs, cross one edge
    task automatic step(input logic v, input logic [1:0] s,
                        input logic [15:0] a, input logic [47:0] src);
        check_cycle();
        req_valid = v; req_sel = s; req_addr = a; src_data = src;
        @(posedge clk);
        model_adv(v, s, a, src);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, req_sel, req_addr, src_data);
    endtask

    function automatic logic [47:0] mk_src(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] r);
        return {r, b, a};
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [15:0] a, b, r;
        logic        exp_err;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] exp_last;
        logic [15:0] cap_a, cap_d;
        logic [15:0] ra, rb, rr, rad;

        vecs[0] = '{sel: 2'd0, addr: 16'h1000, a: 16'hAAAA, b: 16'hBBBB, r: 16'hCCCC, exp_err: 1'b0, exp_data: 16'hAAAA};
        vecs[1] = '{sel: 2'd1, addr: 16'hFFFF, a: 16'h0001, b: 16'h8000, r: 16'h7FFF, exp_err: 1'b0, exp_data: 16'h8000};
        vecs[2] = '{sel: 2'd2, addr: 16'h0000, a: 16'h1111, b: 16'h2222, r: 16'hFFFF, exp_err: 1'b0, exp_data: 16'hFFFF};
        vecs[3] = '{sel: 2'd3, addr: 16'h5555, a: 16'h3333, b: 16'h4444, r: 16'h5555, exp_err: 1'b1, exp_data: 16'h0000};
        vecs[4] = '{sel: 2'd1, addr: 16'h00FF, a: 16'hDEAD, b: 16'h0000, r: 16'hBEEF, exp_err: 1'b0, exp_data: 16'h0000};
        vecs[5] = '{sel: 2'd0, addr: 16'hA5A5, a: 16'h5A5A, b: 16'h0F0F, r: 16'hF0F0, exp_err: 1'b0, exp_data: 16'h5A5A};

        // Reset state while rst is held
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_ce_n", ram_ce_n, 1'b1);
        chk("rst_we_n", ram_we_n, 1'b1);
        chk("rst_oe", ram_data_oe, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", sel_err, 1'b0);
        chk("rst_addr", ram_addr, 16'h0);
        chk("rst_data", ram_data_out, 16'h0);
        chk("rst_last", last_data, 16'h0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_ready_after", req_ready, 1'b1);
        @(negedge clk);

        // Test 1: single REGB write, explicit cycle timing
        step(1'b1, 2'(SRC_REGB), 16'h0040, mk_src(16'h1111, 16'hBEEF, 16'h2222));
        for (int k = 1; k <= 5; k++) begin
            chk("t1_we_n", ram_we_n, !(k == 2 || k == 3));
            chk("t1_ce_n", ram_ce_n, !(k <= 4));
            chk("t1_done", done, k == 5);
            chk("t1_data", ram_data_out, 16'hBEEF);
            chk("t1_addr", ram_addr, 16'h0040);
            step(1'b0, 2'd0, 16'h0, '0);
        end
        chk("t1_last", last_data, 16'hBEEF);

        // Test 2: back-to-back, valid held high across the done cycle
        step(1'b1, 2'(SRC_REGA), 16'h0100, mk_src(16'h1234, 16'h0, 16'h0));
        for (int k = 1; k <= 10; k++) begin
            chk("t2_we_n", ram_we_n, !(k == 2 || k == 3 || k == 7 || k == 8));
            chk("t2_done", done, k == 5 || k == 10);
            chk("t2_ready", req_ready, k == 5 || k == 10);
            chk("t2_data", ram_data_out, (k <= 5) ? 16'h1234 : 16'h00A8);
            step(k <= 5, 2'(SRC_RA), 16'h0200, mk_src(16'h0, 16'h0, 16'h00A8));
        end
        chk("t2_last", last_data, 16'h00A8);

        // Test 3: out-of-range select is dropped
        step(1'b1, 2'd3, 16'h0300, mk_src(16'h9999, 16'h9999, 16'h9999));
        chk("t3_err", sel_err, 1'b1);
        chk("t3_ready", req_ready, 1'b1);
        chk("t3_ce_n", ram_ce_n, 1'b1);
        chk("t3_we_n", ram_we_n, 1'b1);
        chk("t3_data", ram_data_out, 16'h00A8);
        chk("t3_addr", ram_addr, 16'h0200);
        step(1'b0, 2'd0, 16'h0, '0);
        chk("t3_err_pulse", sel_err, 1'b0);

        // Vector table
        exp_last = 16'h00A8;
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].sel, vecs[i].addr, mk_src(vecs[i].a, vecs[i].b, vecs[i].r));
            chk("vec_err", sel_err, vecs[i].exp_err);
            if (!vecs[i].exp_err) exp_last = vecs[i].exp_data;
            idle(T + 1);
            chk("vec_last", last_data, exp_last);
        end

        // Test 6: inputs churn during a write; captured values must hold
        step(1'b1, 2'd1, 16'hC0DE, mk_src(16'h0, 16'h7E57, 16'h0));
        cap_a = 16'hC0DE;
        cap_d = 16'h7E57;
        for (int k = 1; k <= 6; k++) begin
            chk("t6_addr", ram_addr, cap_a);
            chk("t6_data", ram_data_out, cap_d);
            step(k <= 4, 2'(k % 3), 16'($urandom()), {16'($urandom()), 16'($urandom()), 16'($urandom())});
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ra = 16'($urandom()); rb = 16'($urandom()); rr = 16'($urandom()); rad = 16'($urandom());
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rad, mk_src(ra, rb, rr));
        end
        idle(T + 2);

        // Test 4: asynchronous reset while WE is low
        step(1'b1, 2'd0, 16'h0444, mk_src(16'h4444, 16'h0, 16'h0));
        step(1'b0, 2'd0, 16'h0, '0);
        chk("t4_in_we", ram_we_n, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("t4_ce_n", ram_ce_n, 1'b1);
        chk("t4_we_n", ram_we_n, 1'b1);
        chk("t4_oe", ram_data_oe, 1'b0);
        chk("t4_last", last_data, 16'h0);
        chk("t4_ready_in_rst", req_ready, 1'b0);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("t4_ready", req_ready, 1'b1);
        @(posedge clk);
        model_adv(1'b0, 2'd0, 16'h0, '0);
        @(negedge clk);
        idle(T + 2);

        // Test 5a: S=0, W=1, H=0
        req_sel = 2'd1; req_addr = 16'h0C00; src_data = mk_src(16'h0, 16'h5A5A, 16'h0);
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("c0_we_n", c0_we_n, k != 1);
            chk("c0_ce_n", c0_ce_n, k != 1);
            chk("c0_oe", c0_oe, k == 1);
            chk("c0_done", c0_done, k == 2);
            chk("c0_ready", c0_ready, k != 1);
            @(negedge clk);
        end
        chk("c0_last", c0_last, 16'h5A5A);
        chk("c0_addr", c0_addr, 16'h0C00);
        chk("c0_data", c0_data, 16'h5A5A);
        chk("c0_err", c0_err, 1'b0);

        // Test 5b: S=2, W=2, H=3
        req_sel = 2'd2; req_addr = 16'h0C02; src_data = mk_src(16'h0, 16'h0, 16'h6B6B);
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk("c2_we_n", c2_we_n, !(k == 3 || k == 4));
            chk("c2_ce_n", c2_ce_n, !(k <= 7));
            chk("c2_oe", c2_oe, k <= 7);
            chk("c2_done", c2_done, k == 8);
            chk("c2_ready", c2_ready, k >= 8);
            @(negedge clk);
        end
        chk("c2_last", c2_last, 16'h6B6B);
        chk("c2_addr", c2_addr, 16'h0C02);
        chk("c2_data", c2_data, 16'h6B6B);
        chk("c2_err", c2_err, 1'b0);

        // Default instance stayed idle throughout the corner runs
        check_cycle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
